// File: rtl/syn_counter.sv
// syn_counter: free-running up/down counter with wrap at MAX_VAL and a
// terminal-count flag derived from the registered count and current mode.
// Optional build macro SYN_COUNTER_SATURATE_EN replaces wrap-around with
// saturation (up holds at MAX_VAL, down holds at 0).
module syn_counter #(
  parameter int unsigned WIDTH   = 5,
  parameter int unsigned MAX_VAL = 31
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mode,
  output logic [WIDTH-1:0] counter,
  output logic             tc
);

  localparam logic [WIDTH-1:0] MAX_V  = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] ZERO_V = '0;
  localparam logic [WIDTH-1:0] ONE_V  = WIDTH'(1);

`ifdef SYN_COUNTER_SATURATE_EN
  // Terminal values hold instead of wrapping.
  localparam logic [WIDTH-1:0] UP_WRAP_V = MAX_V;
  localparam logic [WIDTH-1:0] DN_WRAP_V = ZERO_V;
`else
  // Terminal values wrap to the opposite end of the range.
  localparam logic [WIDTH-1:0] UP_WRAP_V = ZERO_V;
  localparam logic [WIDTH-1:0] DN_WRAP_V = MAX_V;
`endif

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic             over_max;

  // Out-of-range values (only possible when MAX_VAL < 2^WIDTH-1) recover to 0;
  // compared at 32 bits so the check stays meaningful for every parameter set.
  assign over_max = 32'(count_q) > MAX_VAL;

  // Next-count selection: recovery, then direction with terminal handling.
  always_comb begin
    count_d = count_q;
    if (over_max) begin
      count_d = ZERO_V;
    end else if (!mode) begin
      if (count_q == MAX_V) begin
        count_d = UP_WRAP_V;
      end else begin
        count_d = count_q + ONE_V;
      end
    end else begin
      if (count_q == ZERO_V) begin
        count_d = DN_WRAP_V;
      end else begin
        count_d = count_q - ONE_V;
      end
    end
  end

  // Count register; reset clears it immediately, independent of the clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= ZERO_V;
    end else begin
      count_q <= count_d;
    end
  end

  assign counter = count_q;

  // Terminal flag follows the live mode so a direction change re-evaluates it at once.
  assign tc = (!mode && (count_q == MAX_V)) || (mode && (count_q == ZERO_V));

endmodule

// File: tb/tb_syn_counter.sv
// tb_syn_counter: randomized scoreboard bench for syn_counter; a reference
// model queues expected {counter, tc} and a monitor checks them after each
// rising edge or on an asynchronous-reset strobe.
module tb_syn_counter;

  localparam int unsigned WIDTH = 5;
  localparam int          MAXV  = 31;

  logic             clk = 1'b0;
  logic             rst;
  logic             mode;
  logic [WIDTH-1:0] counter;
  logic             tc;
  logic             chk_stb = 1'b0;

  typedef struct {
    int    c;
    bit    t;
    string tag;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   checks   = 0;
  int   failures = 0;
  int   exp_c    = 0;

  syn_counter #(.WIDTH(WIDTH), .MAX_VAL(MAXV)) dut (
    .clk     (clk),
    .rst     (rst),
    .mode    (mode),
    .counter (counter),
    .tc      (tc)
  );

  always #10 clk = ~clk;

  // Reference next value from the counting rules, using modular arithmetic.
  function automatic int nxt(input int c, input bit m);
    if (c > MAXV) return 0;
`ifdef SYN_COUNTER_SATURATE_EN
    if (!m) return (c + 1 > MAXV) ? MAXV : c + 1;
    return (c - 1 < 0) ? 0 : c - 1;
`else
    if (!m) return (c + 1) % (MAXV + 1);
    return (c + MAXV) % (MAXV + 1);
`endif
  endfunction

  function automatic bit tcf(input int c, input bit m);
    return (!m && c == MAXV) || (m && c == 0);
  endfunction

  task automatic push(input string tag);
    exp_t x;
    x.c   = exp_c;
    x.t   = tcf(exp_c, mode);
    x.tag = tag;
    q.push_back(x);
  endtask

  task automatic strobe();
    chk_stb = 1'b1;
    #1 chk_stb = 1'b0;
  endtask

  // One clock of stimulus: drive at the falling edge, predict the next rising edge.
  task automatic step(input bit r, input bit m, input string tag);
    @(negedge clk);
    rst  = r;
    mode = m;
    exp_c = r ? 0 : nxt(exp_c, m);
    push(tag);
  endtask

  // Reset pulse wholly between two rising edges.
  task automatic pulse_rst(input bit m, input string tag);
    @(negedge clk);
    mode = m;
    #2 rst = 1'b1;
    exp_c = 0;
    push({tag, "_async"});
    strobe();
    #2 rst = 1'b0;
    exp_c = nxt(0, m);
    push({tag, "_after"});
  endtask

  // Monitor: compare the oldest expectation whenever the DUT output settles.
  initial begin
    forever begin
      @(posedge clk or posedge chk_stb);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if (counter !== WIDTH'(e.c)) begin
          failures++;
          $display("FAIL %s counter: got %0d expected %0d at %0t", e.tag, counter, e.c, $time);
        end
        checks++;
        if (tc !== e.t) begin
          failures++;
          $display("FAIL %s tc: got %b expected %b (counter %0d) at %0t", e.tag, tc, e.t, counter, $time);
        end
      end
    end
  end

  initial begin
    int g;
    bit r;
    bit m;
    rst  = 1'b1;
    mode = 1'b0;
    #1;
    exp_c = 0;
    push("reset_hold");
    strobe();
    #3 rst = 1'b0;
    exp_c = nxt(0, 1'b0);
    push("reset_seq1");
    step(1'b0, 1'b0, "reset_seq2");
    step(1'b0, 1'b0, "reset_seq3");

    g = 0;
    while (exp_c != 5 && g < 64) begin step(1'b0, 1'b0, "to5"); g++; end
    pulse_rst(1'b0, "rst_at5");

    g = 0;
    while (exp_c != 29 && g < 64) begin step(1'b0, 1'b0, "to29"); g++; end
    repeat (4) step(1'b0, 1'b0, "up_wrap");

    g = 0;
    while (exp_c != 20 && g < 64) begin step(1'b0, 1'b0, "to20"); g++; end
    repeat (2) step(1'b0, 1'b1, "dir_switch");
    g = 0;
    while (exp_c != 1 && g < 64) begin step(1'b0, 1'b1, "down_to1"); g++; end
    repeat (2) step(1'b0, 1'b1, "down_wrap");

    repeat (2) step(1'b1, 1'b1, "rst_down");
    repeat (2) step(1'b0, 1'b0, "rst_release_up");

    repeat (400) begin
      m = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 29) == 0) begin
        pulse_rst(m, "rand_pulse");
      end else begin
        r = ($urandom_range(0, 19) == 0);
        step(r, m, "rand");
      end
    end

    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
